// File: rtl/seg7_scan_driver.sv
// Scanned multi-digit 7-segment driver: double-buffered hex value, per-digit
// decode with decimal point, blanking and leading-zero suppression.
module seg7_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  JM1222HM_clk,
  input  logic                  JM1222HM_rst_n,
  input  logic [4*DIGITS-1:0]   JM1222HM_value,
  input  logic [DIGITS-1:0]     JM1222HM_dp,
  input  logic [DIGITS-1:0]     JM1222HM_blank,
  input  logic                  JM1222HM_lz_en,
  input  logic                  JM1222HM_load,
  output logic [6:0]            JM1222HM_seg_n,
  output logic                  JM1222HM_dp_n,
  output logic [DIGITS-1:0]     JM1222HM_an_n,
  output logic                  JM1222HM_frame
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [PW-1:0]         pcnt;
  logic [IW-1:0]         idx;
  logic                  dwell_end;
  logic                  boundary;
  logic                  bnd_q;

  logic [4*DIGITS-1:0]   pend_value;
  logic [DIGITS-1:0]     pend_dp;
  logic [DIGITS-1:0]     pend_blank;
  logic                  pend_lz;
  logic                  pend_valid;

  logic [4*DIGITS-1:0]   disp_value;
  logic [DIGITS-1:0]     disp_dp;
  logic [DIGITS-1:0]     disp_blank;
  logic                  disp_lz;

  logic [DIGITS-1:0]     supp;
  logic                  zero_run;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_dark;
  logic [DIGITS-1:0]     an_next;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign dwell_end = (pcnt == PCNT_LAST);
  assign boundary  = dwell_end && (idx == IDX_LAST);

  always_ff @(posedge JM1222HM_clk) begin
    if (!JM1222HM_rst_n) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (dwell_end) begin
      pcnt <= '0;
      idx  <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  // Display swaps only at frame boundaries so a frame never mixes two values;
  // a load on the boundary cycle lands in pending after the older one is applied.
  always_ff @(posedge JM1222HM_clk) begin
    if (!JM1222HM_rst_n) begin
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_lz    <= 1'b0;
      pend_valid <= 1'b0;
      disp_value <= '0;
      disp_dp    <= '0;
      disp_blank <= '0;
      disp_lz    <= 1'b0;
    end else begin
      if (boundary && pend_valid) begin
        disp_value <= pend_value;
        disp_dp    <= pend_dp;
        disp_blank <= pend_blank;
        disp_lz    <= pend_lz;
        pend_valid <= 1'b0;
      end
      if (JM1222HM_load) begin
        pend_value <= JM1222HM_value;
        pend_dp    <= JM1222HM_dp;
        pend_blank <= JM1222HM_blank;
        pend_lz    <= JM1222HM_lz_en;
        pend_valid <= 1'b1;
      end
    end
  end

  // Walk from the most significant digit down; a digit is suppressed while
  // every nibble from it upward is zero. Digit 0 always shows.
  always_comb begin
    zero_run = 1'b1;
    supp     = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (disp_value[4*k +: 4] == 4'h0);
      supp[k]  = disp_lz & zero_run & (k != 0);
    end
  end

  always_comb begin
    cur_nib  = '0;
    cur_dp   = 1'b0;
    cur_dark = 1'b0;
    an_next  = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_nib    = disp_value[4*k +: 4];
        cur_dp     = disp_dp[k];
        cur_dark   = disp_blank[k] | supp[k];
        an_next[k] = 1'b0;
      end
    end
  end

  // Anode and segment data share one register stage so they switch together;
  // frame is delayed one extra stage to line up with digit 0 appearing.
  always_ff @(posedge JM1222HM_clk) begin
    if (!JM1222HM_rst_n) begin
      JM1222HM_seg_n <= 7'h7F;
      JM1222HM_dp_n  <= 1'b1;
      JM1222HM_an_n  <= '1;
      JM1222HM_frame <= 1'b0;
      bnd_q          <= 1'b0;
    end else begin
      JM1222HM_seg_n <= cur_dark ? 7'h7F : ~hex_to_seg(cur_nib);
      JM1222HM_dp_n  <= cur_dark | ~cur_dp;
      JM1222HM_an_n  <= an_next;
      bnd_q          <= boundary;
      JM1222HM_frame <= bnd_q;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: frame-level reference model feeds an expected
// queue, a negedge monitor compares every output cycle.
module tb_seg7_scan_driver;

  localparam int D  = 4;
  localparam int RD = 4;
  localparam int F  = D * RD;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        lz_en;
  logic        load;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(D), .REFRESH_DIV(RD)) dut (
    .JM1222HM_clk   (clk),
    .JM1222HM_rst_n (rst_n),
    .JM1222HM_value (value),
    .JM1222HM_dp    (dp),
    .JM1222HM_blank (blank),
    .JM1222HM_lz_en (lz_en),
    .JM1222HM_load  (load),
    .JM1222HM_seg_n (seg_n),
    .JM1222HM_dp_n  (dp_n),
    .JM1222HM_an_n  (an_n),
    .JM1222HM_frame (frame)
  );

  // ---------------- reference model ----------------
  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int          m_c;
  logic [15:0] m_pv, m_dv;
  logic [3:0]  m_pdp, m_ddp, m_pbl, m_dbl;
  logic        m_plz, m_dlz, m_pvalid;

  logic [12:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          mon_n  = 0;
  logic [12:0] mon_e, mon_g;

  // Output seen after the edge that leaves cycle m_c: digit shown depends only
  // on how many cycles have elapsed since reset release.
  function automatic logic [12:0] model_out();
    int         k;
    logic       dark;
    logic [3:0] nib;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dpn;
    logic       frm;
    k    = (m_c / RD) % D;
    nib  = m_dv[4*k +: 4];
    dark = m_dbl[k] || (m_dlz && k != 0 && (m_dv >> (4*k)) == 16'h0);
    seg  = dark ? 7'h7F : ~tbl[nib];
    dpn  = dark ? 1'b1 : ~m_ddp[k];
    an   = ~(4'b0001 << k);
    frm  = (m_c > 0) && (m_c % F == 0);
    return {frm, an, dpn, seg};
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      exp_q.push_back({1'b0, 4'hF, 1'b1, 7'h7F});
      m_c = 0;
      m_pv = '0; m_dv = '0; m_pdp = '0; m_ddp = '0; m_pbl = '0; m_dbl = '0;
      m_plz = 1'b0; m_dlz = 1'b0; m_pvalid = 1'b0;
    end else begin
      exp_q.push_back(model_out());
      if ((m_c % F == F - 1) && m_pvalid) begin
        m_dv = m_pv; m_ddp = m_pdp; m_dbl = m_pbl; m_dlz = m_plz;
        m_pvalid = 1'b0;
      end
      if (load) begin
        m_pv = value; m_pdp = dp; m_pbl = blank; m_plz = lz_en;
        m_pvalid = 1'b1;
      end
      m_c++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc(input int n);
    repeat (n) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d,
                         input logic [3:0] b, input logic lz);
    value = v; dp = d; blank = b; lz_en = lz; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic align_to(input int phase);
    while (m_c % F != phase) step();
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_n++;
        mon_e = exp_q.pop_front();
        mon_g = {frame, an_n, dp_n, seg_n};
        checks++;
        if (mon_g !== mon_e) begin
          errors++;
          $display("FAIL out cycle%0d got frame=%b an_n=%h dp_n=%b seg_n=%h exp frame=%b an_n=%h dp_n=%b seg_n=%h",
                   mon_n, mon_g[12], mon_g[11:8], mon_g[7], mon_g[6:0],
                   mon_e[12], mon_e[11:8], mon_e[7], mon_e[6:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [15:0] sweep [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};

  initial begin
    rst_n = 1'b0; load = 1'b1; value = 16'hABCD; dp = 4'hF; blank = 4'h0; lz_en = 1'b1;
    cyc(3);
    rst_n = 1'b1; load = 1'b0;
    cyc(2);

    do_load(16'h1234, 4'h0, 4'h0, 1'b0);
    cyc(2 * F + 4);

    for (int i = 0; i < 4; i++) begin
      do_load(sweep[i], 4'h0, 4'h0, 1'b0);
      cyc(2 * F);
    end

    do_load(16'h0070, 4'b0001, 4'b0000, 1'b1);
    cyc(2 * F);
    do_load(16'h0000, 4'b0000, 4'b0001, 1'b1);
    cyc(2 * F);

    align_to(5);
    do_load(16'h1111, 4'h0, 4'h0, 1'b0);
    step();
    do_load(16'h2222, 4'h2, 4'h0, 1'b0);
    cyc(2 * F);

    align_to(F - 1);
    do_load(16'h3333, 4'h8, 4'h0, 1'b0);
    cyc(3 * F);

    while ((m_c / RD) % D != 2) step();
    do_load(16'h5555, 4'hF, 4'h0, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cyc(2 * F + 2);

    for (int i = 0; i < 600; i++) begin
      load  = ($urandom_range(0, 7) == 0);
      value = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      dp    = 4'($urandom_range(0, 15));
      blank = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      lz_en = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 249) != 0);
      step();
    end
    rst_n = 1'b1; load = 1'b0;
    cyc(F);

    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending entries exp 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
